// File: rtl/ahb_subordinate_memory_pkg.sv
// Shared AHB-Lite types and bus-wide constants.
// Purpose: enums for transfer/size/response/direction and the subordinate FSM.
package AhbGlobalPackage;

   localparam int ADDR_WIDTH        = 32;
   localparam int DATA_WIDTH        = 8;
   localparam int SLAVE_MEMORY_SIZE = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } ahbTransferEnum;

   typedef enum logic [2:0] {
      BYTE        = 3'd0,
      HALFWORD    = 3'd1,
      WORD        = 3'd2,
      DOUBLEWORD  = 3'd3,
      LINE4       = 3'd4,
      LINE8       = 3'd5,
      LINE16      = 3'd6,
      LINE32      = 3'd7
   } ahbHsizeEnum;

   typedef enum logic {
      OKAY  = 1'b0,
      ERROR = 1'b1
   } ahbRespEnum;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } ahbWriteEnum;

   typedef enum logic [1:0] {
      SUB_IDLE,
      SUB_DATA,
      SUB_ERR1,
      SUB_ERR2
   } ahbSubStateEnum;

endpackage

// File: rtl/ahb_subordinate_byte_ram.sv
// Byte-lane RAM: per-lane write enables at a bus-aligned base, async read.
// Ports: clk, base (aligned byte index), we (lane enables), wdata, rdata.
module ahb_subordinate_byte_ram #(
   parameter int ADDR_BITS = 12,
   parameter int LANES     = 4
) (
   input  logic                   clk,
   input  logic [ADDR_BITS-1:0]   base,
   input  logic [LANES-1:0]       we,
   input  logic [LANES*8-1:0]     wdata,
   output logic [LANES*8-1:0]     rdata
);

   logic [7:0] mem [2**ADDR_BITS];

   // Contents deliberately survive reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++) begin
         if (we[i]) mem[base + ADDR_BITS'(i)] <= wdata[8*i +: 8];
      end
   end

   always_comb begin
      rdata = '0;
      for (int i = 0; i < LANES; i++) begin
         rdata[8*i +: 8] = mem[base + ADDR_BITS'(i)];
      end
   end

endmodule

// File: rtl/ahb_subordinate_memory.sv
// AHB-Lite subordinate memory: decode, wait states, 2-cycle ERROR, byte lanes.
// Ports: hclk/hreset, AHB address+data phase inputs, cfg_wait_states; hreadyout/hresp/hrdata/hexokay.
module ahb_subordinate_memory #(
   parameter int ADDR_WIDTH    = AhbGlobalPackage::ADDR_WIDTH,
   parameter int DATA_WIDTH    = AhbGlobalPackage::DATA_WIDTH,
   parameter int MEM_ADDR_BITS = AhbGlobalPackage::SLAVE_MEMORY_SIZE,
   parameter logic [ADDR_WIDTH-1:0] MIN_ADDR = '0,
   parameter logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(32'h0000_0FFF)
) (
   input  logic                    hclk,
   input  logic                    hreset,
   input  logic                    hselx,
   input  logic [ADDR_WIDTH-1:0]   haddr,
   input  logic [1:0]              htrans,
   input  logic                    hwrite,
   input  logic [2:0]              hsize,
   input  logic [2:0]              hburst,
   input  logic [3:0]              hprot,
   input  logic                    hmastlock,
   input  logic [DATA_WIDTH-1:0]   hwdata,
   input  logic [DATA_WIDTH/8-1:0] hwstrb,
   input  logic                    hready,
   input  logic [3:0]              cfg_wait_states,
   output logic                    hreadyout,
   output logic                    hresp,
   output logic [DATA_WIDTH-1:0]   hrdata,
   output logic                    hexokay
);

   import AhbGlobalPackage::*;

   localparam int LANES = DATA_WIDTH / 8;
   localparam logic [MEM_ADDR_BITS-1:0] LANE_MASK = MEM_ADDR_BITS'(LANES - 1);

   ahbSubStateEnum             state;
   logic [3:0]                 wait_cnt;
   logic [MEM_ADDR_BITS-1:0]   a_idx;
   logic                       a_write;
   logic [2:0]                 a_size;

   logic                       borrow;
   logic [ADDR_WIDTH-1:0]      offset;
   logic [ADDR_WIDTH-1:0]      align_mask;
   logic                       accept;
   logic                       illegal;
   logic                       data_done;
   logic [LANES-1:0]           lane_sel;
   logic [DATA_WIDTH-1:0]      lane_bits;
   logic [DATA_WIDTH-1:0]      ram_rdata;
   logic [LANES-1:0]           ram_we;
   int                         lane_off;
   int                         nbytes;
   logic                       unused;

   // Offset at full width; the borrow flags haddr < MIN_ADDR.
   assign {borrow, offset} = {1'b0, haddr} - {1'b0, MIN_ADDR};
   assign align_mask = ADDR_WIDTH'((32'd1 << hsize) - 32'd1);

   assign illegal = borrow
                 || (haddr > MAX_ADDR)
                 || ((32'd8 << hsize) > 32'(DATA_WIDTH))
                 || ((haddr & align_mask) != '0);

   // Only a ready (idle or completing) subordinate can take a new address phase.
   assign accept = hselx && hready && hreadyout
                && (htrans == NONSEQ || htrans == SEQ);

   assign data_done = (state == SUB_DATA) && hreadyout;

   always_comb begin
      lane_off  = int'(a_idx & LANE_MASK);
      nbytes    = 1 << a_size;
      lane_sel  = '0;
      lane_bits = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_sel[i] = (i >= lane_off) && (i < lane_off + nbytes);
         lane_bits[8*i +: 8] = {8{lane_sel[i]}};
      end
   end

   assign ram_we  = {LANES{data_done && a_write}} & hwstrb & lane_sel;
   assign hrdata  = (data_done && !a_write) ? (ram_rdata & lane_bits) : '0;
   assign hexokay = 1'b0;
   assign unused  = ^{hburst, hprot, hmastlock, offset[ADDR_WIDTH-1:MEM_ADDR_BITS]};

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state     <= SUB_IDLE;
         wait_cnt  <= '0;
         hreadyout <= 1'b1;
         hresp     <= OKAY;
         a_idx     <= '0;
         a_write   <= 1'b0;
         a_size    <= '0;
      end else if (accept) begin
         a_idx    <= offset[MEM_ADDR_BITS-1:0];
         a_write  <= hwrite;
         a_size   <= hsize;
         wait_cnt <= cfg_wait_states;
         if (illegal) begin
            state     <= SUB_ERR1;
            hreadyout <= 1'b0;
            hresp     <= ERROR;
         end else begin
            state     <= SUB_DATA;
            hreadyout <= (cfg_wait_states == 4'd0);
            hresp     <= OKAY;
         end
      end else begin
         unique case (state)
            SUB_IDLE: begin
               hreadyout <= 1'b1;
               hresp     <= OKAY;
            end
            SUB_DATA: begin
               if (wait_cnt != 4'd0) begin
                  wait_cnt  <= wait_cnt - 4'd1;
                  hreadyout <= (wait_cnt == 4'd1);
               end else begin
                  state     <= SUB_IDLE;
                  hreadyout <= 1'b1;
                  hresp     <= OKAY;
               end
            end
            SUB_ERR1: begin
               state     <= SUB_ERR2;
               hreadyout <= 1'b1;
            end
            SUB_ERR2: begin
               state <= SUB_IDLE;
               hresp <= OKAY;
            end
         endcase
      end
   end

   ahb_subordinate_byte_ram #(
      .ADDR_BITS (MEM_ADDR_BITS),
      .LANES     (LANES)
   ) u_ram (
      .clk   (hclk),
      .base  (a_idx & ~LANE_MASK),
      .we    (ram_we),
      .wdata (hwdata),
      .rdata (ram_rdata)
   );

endmodule
